// File: rtl/mux8_frame_sequencer_pkg.sv
// Shared state encodings and frame constants for the 8:1 mux frame sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mux8_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [2:0] SEL_FIRST_LSB  = 3'd0;
  localparam logic [2:0] SEL_FIRST_MSB  = 3'd7;
  localparam logic [3:0] BITS_PER_FRAME = 4'd8;

  // Bit-counter value while the final frame bit is on the mux.
  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_FRAME - 4'd1);

  // Next select value when stepping through the frame.
  function automatic logic [2:0] sel_step(input logic [2:0] cur, input bit msb_first);
    return msb_first ? (cur - 3'd1) : (cur + 3'd1);
  endfunction

endpackage

// File: rtl/mux8_frame_sequencer_period_counter.sv
// 4-bit wrapping counter 0..LIMIT-1; reports whether its next value is terminal.
// Latency: count updates one cycle after en/clr; term_nxt is combinational.
// Backpressure: none; en simply freezes the count.
module mux8_period_counter #(
  parameter int unsigned LIMIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term_nxt
);

  localparam logic [3:0] LAST = 4'(LIMIT - 1);

  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  // Clear wins over enable; the count wraps to zero after the terminal value.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = 4'd0;
    end else if (en) begin
      cnt_nxt = (cnt == LAST) ? 4'd0 : (cnt + 4'd1);
    end
  end

  assign term_nxt = (cnt_nxt == LAST);

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/mux_8_1.sv
// Plain 8:1 bit multiplexer driven by the frame sequencer.
// Latency: combinational.
// Backpressure: none.
module mux_8_1 (
  input  logic [7:0] data_in,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = data_in[sel];

endmodule

// File: rtl/mux8_frame_sequencer.sv
// Latches an 8-bit word and walks the mux select over all 8 bits with bit/frame qualifiers.
// Latency: bit_valid one cycle after accept; frame lasts 8*BIT_CYCLES cycles; done one cycle after.
// Backpressure: in_ready only in IDLE or on the last bit cycle when no gap is configured.
module mux8_frame_sequencer
  import mux8_frame_sequencer_pkg::*;
#(
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic [2:0] sel,
  output logic       bit_valid,
  output logic       bit_tick,
  output logic       frame_last,
  output logic       done
);

  // The gap counter is never enabled when GAP_CYCLES is 0; keep its limit legal anyway.
  localparam int unsigned GAP_LIMIT = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam logic        HAS_GAP   = (GAP_CYCLES != 0);
  localparam logic [2:0]  SEL_FIRST = MSB_FIRST ? SEL_FIRST_MSB : SEL_FIRST_LSB;

  state_t     state;
  state_t     state_n;
  logic [2:0] sel_n;
  logic [2:0] bcnt;
  logic [2:0] bcnt_n;
  logic [7:0] data_n;
  logic       pclr;
  logic       pen;
  logic       gclr;
  logic       gen;
  logic       pterm_nxt;
  logic       gterm_nxt;
  logic       gap_last;
  logic       accept;
  logic       last_bit;

  assign in_ready = rst_n & ((state == ST_IDLE) |
                             ((state == ST_SEND) & frame_last & bit_tick & ~HAS_GAP));
  assign accept   = in_valid & in_ready;
  // bit_tick/frame_last are registered decodes of the counters, so they describe the current cycle.
  assign last_bit = (state == ST_SEND) & bit_tick & frame_last;

  mux8_period_counter #(.LIMIT(BIT_CYCLES)) u_period (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pclr),
    .en       (pen),
    .term_nxt (pterm_nxt)
  );

  mux8_period_counter #(.LIMIT(GAP_LIMIT)) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (gclr),
    .en       (gen),
    .term_nxt (gterm_nxt)
  );

  // Next-state, select stepping and word capture.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    bcnt_n  = bcnt;
    data_n  = data_out;
    pclr    = 1'b0;
    pen     = 1'b0;
    gclr    = 1'b0;
    gen     = 1'b0;
    case (state)
      ST_IDLE: begin
      end
      ST_SEND: begin
        pen = 1'b1;
        if (bit_tick) begin
          if (frame_last) begin
            // sel and bit count hold on the final bit so no wrap is ever visible.
            if (!accept) begin
              if (HAS_GAP) begin
                state_n = ST_GAP;
                gclr    = 1'b1;
              end else begin
                state_n = ST_IDLE;
              end
            end
          end else begin
            sel_n  = sel_step(sel, MSB_FIRST);
            bcnt_n = bcnt + 3'd1;
          end
        end
      end
      ST_GAP: begin
        gen = 1'b1;
        if (gap_last) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // An accept overrides everything above: fresh word, fresh counters, first select.
    if (accept) begin
      state_n = ST_SEND;
      data_n  = in_data;
      sel_n   = SEL_FIRST;
      bcnt_n  = 3'd0;
      pclr    = 1'b1;
    end
  end

  // State and registered qualifiers, all decoded from next-cycle values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      data_out   <= 8'd0;
      sel        <= 3'd0;
      bcnt       <= 3'd0;
      bit_valid  <= 1'b0;
      bit_tick   <= 1'b0;
      frame_last <= 1'b0;
      done       <= 1'b0;
      gap_last   <= 1'b0;
    end else begin
      state      <= state_n;
      data_out   <= data_n;
      sel        <= sel_n;
      bcnt       <= bcnt_n;
      bit_valid  <= (state_n == ST_SEND);
      bit_tick   <= (state_n == ST_SEND) & pterm_nxt;
      frame_last <= (state_n == ST_SEND) & (bcnt_n == LAST_BIT);
      done       <= last_bit;
      gap_last   <= (state_n == ST_GAP) & gterm_nxt;
    end
  end

endmodule

// File: tb/tb_mux8_frame_sequencer.sv
// Directed bench: four sequencer configurations, each feeding its own 8:1 mux.
// u0 LSB/1/0, u1 MSB/1/0, u2 LSB/3/0, u3 LSB/1/2 (MSB_FIRST/BIT_CYCLES/GAP_CYCLES).
// All checks are immediate assertions against hand-derived expectations.
module tb_mux8_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ind [4];
  logic       inv [4];
  logic       rdy [4];
  logic [7:0] dout [4];
  logic [2:0] sl [4];
  logic       bv [4];
  logic       bt [4];
  logic       fl [4];
  logic       dn [4];
  logic       y [4];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mux8_frame_sequencer #(.MSB_FIRST(1'b0), .BIT_CYCLES(1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(ind[0]), .in_valid(inv[0]), .in_ready(rdy[0]),
    .data_out(dout[0]), .sel(sl[0]), .bit_valid(bv[0]), .bit_tick(bt[0]),
    .frame_last(fl[0]), .done(dn[0]));
  mux8_frame_sequencer #(.MSB_FIRST(1'b1), .BIT_CYCLES(1), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(ind[1]), .in_valid(inv[1]), .in_ready(rdy[1]),
    .data_out(dout[1]), .sel(sl[1]), .bit_valid(bv[1]), .bit_tick(bt[1]),
    .frame_last(fl[1]), .done(dn[1]));
  mux8_frame_sequencer #(.MSB_FIRST(1'b0), .BIT_CYCLES(3), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(ind[2]), .in_valid(inv[2]), .in_ready(rdy[2]),
    .data_out(dout[2]), .sel(sl[2]), .bit_valid(bv[2]), .bit_tick(bt[2]),
    .frame_last(fl[2]), .done(dn[2]));
  mux8_frame_sequencer #(.MSB_FIRST(1'b0), .BIT_CYCLES(1), .GAP_CYCLES(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(ind[3]), .in_valid(inv[3]), .in_ready(rdy[3]),
    .data_out(dout[3]), .sel(sl[3]), .bit_valid(bv[3]), .bit_tick(bt[3]),
    .frame_last(fl[3]), .done(dn[3]));

  mux_8_1 m0 (.data_in(dout[0]), .sel(sl[0]), .y(y[0]));
  mux_8_1 m1 (.data_in(dout[1]), .sel(sl[1]), .y(y[1]));
  mux_8_1 m2 (.data_in(dout[2]), .sel(sl[2]), .y(y[2]));
  mux_8_1 m3 (.data_in(dout[3]), .sel(sl[3]), .y(y[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word for one edge, then drop in_valid; returns in bit-1 cycle.
  task automatic send(input int u, input logic [7:0] w);
    ind[u] = w;
    inv[u] = 1'b1;
    tick();
    inv[u] = 1'b0;
  endtask

  // Walks a whole frame starting in its first bit cycle, ending in its last bit cycle.
  task automatic check_frame(input int u, input logic [7:0] w, input bit msb, input int bc,
                             input bit gap, input bit done_first);
    logic [2:0] es;
    for (int b = 0; b < 8; b++) begin
      for (int c = 1; c <= bc; c++) begin
        if (!(b == 0 && c == 1)) tick();
        es = msb ? 3'(7 - b) : 3'(b);
        chk($sformatf("u%0d b%0d c%0d sel", u, b, c), 32'(sl[u]), 32'(es));
        chk($sformatf("u%0d b%0d c%0d y", u, b, c), 32'(y[u]), 32'(w[es]));
        chk($sformatf("u%0d b%0d c%0d bit_valid", u, b, c), 32'(bv[u]), 32'd1);
        chk($sformatf("u%0d b%0d c%0d bit_tick", u, b, c), 32'(bt[u]), 32'(c == bc));
        chk($sformatf("u%0d b%0d c%0d frame_last", u, b, c), 32'(fl[u]), 32'(b == 7));
        chk($sformatf("u%0d b%0d c%0d done", u, b, c), 32'(dn[u]),
            32'(done_first && b == 0 && c == 1));
        chk($sformatf("u%0d b%0d c%0d in_ready", u, b, c), 32'(rdy[u]),
            32'(!gap && b == 7 && c == bc));
        chk($sformatf("u%0d b%0d c%0d data_out", u, b, c), 32'(dout[u]), 32'(w));
      end
    end
  endtask

  // Cycle after the last bit: done pulse, qualifiers low, sel and word held; then done drops.
  task automatic check_end(input int u, input logic [7:0] w, input logic [2:0] last_sel);
    tick();
    chk($sformatf("u%0d end done", u), 32'(dn[u]), 32'd1);
    chk($sformatf("u%0d end bit_valid", u), 32'(bv[u]), 32'd0);
    chk($sformatf("u%0d end bit_tick", u), 32'(bt[u]), 32'd0);
    chk($sformatf("u%0d end frame_last", u), 32'(fl[u]), 32'd0);
    chk($sformatf("u%0d end sel hold", u), 32'(sl[u]), 32'(last_sel));
    chk($sformatf("u%0d end data hold", u), 32'(dout[u]), 32'(w));
    chk($sformatf("u%0d end in_ready", u), 32'(rdy[u]), 32'd1);
    tick();
    chk($sformatf("u%0d end+1 done", u), 32'(dn[u]), 32'd0);
    chk($sformatf("u%0d end+1 data hold", u), 32'(dout[u]), 32'(w));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ind[i] = 8'h00;
      inv[i] = 1'b0;
    end

    // Reset state.
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d rst data_out", i), 32'(dout[i]), 32'd0);
      chk($sformatf("u%0d rst sel", i), 32'(sl[i]), 32'd0);
      chk($sformatf("u%0d rst bit_valid", i), 32'(bv[i]), 32'd0);
      chk($sformatf("u%0d rst bit_tick", i), 32'(bt[i]), 32'd0);
      chk($sformatf("u%0d rst frame_last", i), 32'(fl[i]), 32'd0);
      chk($sformatf("u%0d rst done", i), 32'(dn[i]), 32'd0);
      chk($sformatf("u%0d rst in_ready", i), 32'(rdy[i]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("u0 idle in_ready", 32'(rdy[0]), 32'd1);
    tick();

    // LSB-first, one cycle per bit.
    send(0, 8'hA5);
    check_frame(0, 8'hA5, 1'b0, 1, 1'b0, 1'b0);
    check_end(0, 8'hA5, 3'd7);

    // MSB-first.
    send(1, 8'hA5);
    check_frame(1, 8'hA5, 1'b1, 1, 1'b0, 1'b0);
    check_end(1, 8'hA5, 3'd0);

    // Three cycles per bit.
    send(2, 8'h3C);
    check_frame(2, 8'h3C, 1'b0, 3, 1'b0, 1'b0);
    check_end(2, 8'h3C, 3'd7);

    // Back-to-back with in_valid held high; the second word waits until the last bit cycle.
    ind[1] = 8'h3C;
    inv[1] = 1'b1;
    tick();
    ind[1] = 8'hC3;
    check_frame(1, 8'h3C, 1'b1, 1, 1'b0, 1'b0);
    tick();
    inv[1] = 1'b0;
    check_frame(1, 8'hC3, 1'b1, 1, 1'b0, 1'b1);
    check_end(1, 8'hC3, 3'd0);

    // Two forced gap cycles with in_valid held high throughout.
    ind[3] = 8'hFF;
    inv[3] = 1'b1;
    tick();
    check_frame(3, 8'hFF, 1'b0, 1, 1'b1, 1'b0);
    tick();
    chk("u3 gap1 in_ready", 32'(rdy[3]), 32'd0);
    chk("u3 gap1 bit_valid", 32'(bv[3]), 32'd0);
    chk("u3 gap1 done", 32'(dn[3]), 32'd1);
    tick();
    chk("u3 gap2 in_ready", 32'(rdy[3]), 32'd0);
    chk("u3 gap2 bit_valid", 32'(bv[3]), 32'd0);
    chk("u3 gap2 done", 32'(dn[3]), 32'd0);
    chk("u3 gap2 data hold", 32'(dout[3]), 32'hFF);
    tick();
    chk("u3 idle in_ready", 32'(rdy[3]), 32'd1);
    chk("u3 idle bit_valid", 32'(bv[3]), 32'd0);
    ind[3] = 8'h5A;
    tick();
    inv[3] = 1'b0;
    check_frame(3, 8'h5A, 1'b0, 1, 1'b1, 1'b0);

    // Reset in the middle of a frame.
    send(0, 8'hC3);
    tick();
    tick();
    tick();
    tick();
    chk("u0 pre-reset sel", 32'(sl[0]), 32'd4);
    rst_n  = 1'b0;
    ind[0] = 8'h99;
    inv[0] = 1'b1;
    #1;
    chk("u0 in_ready during reset", 32'(rdy[0]), 32'd0);
    tick();
    chk("u0 mid-rst data_out", 32'(dout[0]), 32'd0);
    chk("u0 mid-rst sel", 32'(sl[0]), 32'd0);
    chk("u0 mid-rst bit_valid", 32'(bv[0]), 32'd0);
    chk("u0 mid-rst bit_tick", 32'(bt[0]), 32'd0);
    chk("u0 mid-rst frame_last", 32'(fl[0]), 32'd0);
    chk("u0 mid-rst done", 32'(dn[0]), 32'd0);
    tick();
    chk("u0 rst valid ignored", 32'(dout[0]), 32'd0);
    rst_n  = 1'b1;
    inv[0] = 1'b0;
    #1;
    chk("u0 post-rst in_ready", 32'(rdy[0]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("u0 post-rst idle%0d done", k), 32'(dn[0]), 32'd0);
      chk($sformatf("u0 post-rst idle%0d bit_valid", k), 32'(bv[0]), 32'd0);
    end
    send(0, 8'h81);
    check_frame(0, 8'h81, 1'b0, 1, 1'b0, 1'b0);
    check_end(0, 8'h81, 3'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
